// File: rtl/rr_mux_arb.sv
// ---------------------------------------------------------------------------
// rr_mux_arb
//
// N-channel, WIDTH-bit registered multiplexer with built-in arbitration.
// Each cycle one requesting channel is chosen, either round-robin (MODE 0)
// or by fixed priority with the lowest index winning (MODE 1). The chosen
// word is loaded into a single output register that has its own valid/ready
// handshake. A full output register may be drained and refilled on the same
// edge, so sustained throughput is one word per cycle.
//
// Parameters:
//   WIDTH  data width of each channel and of the output
//   N      number of input channels (N >= 2)
//   MODE   0 = round-robin, 1 = fixed priority (lowest index wins)
//   SEL_W  channel index width, derived from N; do not override
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   [N]        per-channel request
//   in_data    [N*WIDTH]  channel i in bits [i*WIDTH +: WIDTH]
//   in_ready   [N]        one-hot or zero; channel word taken this cycle
//   out_valid             output register holds a word
//   out_data   [WIDTH]    registered word
//   out_sel    [SEL_W]    index of the channel that supplied out_data
//   out_ready             consumer accepts the output word this cycle
//
// in_ready is a combinational function of in_valid, out_valid and out_ready.
// in_data reaches the outputs only through the output register.
// ---------------------------------------------------------------------------
module rr_mux_arb #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int MODE  = 0,
  parameter int SEL_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_sel,
  input  logic                 out_ready
);

  // Round-robin search start. Only meaningful in MODE 0; held at 0 otherwise.
  logic [SEL_W-1:0] ptr;

  logic [SEL_W-1:0] gnt;
  logic             any;
  logic             can_load;
  logic             load;

  // Unpacked view of the packed input bus, indexed by channel.
  logic [WIDTH-1:0] chan_data [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      chan_data[i] = in_data[i*WIDTH +: WIDTH];
    end
  end

  assign any      = |in_valid;
  assign can_load = !out_valid || out_ready;
  assign load     = any && can_load;

  // -------------------------------------------------------------------------
  // Arbitration. Walk the channels starting at the search base (ptr in
  // round-robin mode, 0 in fixed-priority mode) and take the first valid one.
  // The modulo keeps the walk inside 0..N-1 for non-power-of-2 N.
  // -------------------------------------------------------------------------
  always_comb begin
    int               idx;
    logic [SEL_W-1:0] cand;
    logic             found;
    // NOTE: combinational logic uses blocking assignments and gives every
    // output a default first, so no path through the block leaves a value
    // unassigned and no latch is inferred.
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    cand  = '0;
    for (int k = 0; k < N; k++) begin
      if (MODE == 0) begin
        idx = (int'(ptr) + k) % N;
      end else begin
        idx = k;
      end
      cand = SEL_W'(idx);
      if (!found && in_valid[cand]) begin
        gnt   = cand;
        found = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Handshake back to the producers. At most the granted channel sees ready.
  // Gating with rst_n keeps in_ready low for the whole reset interval even
  // though in_valid may already be driven.
  // -------------------------------------------------------------------------
  always_comb begin
    in_ready = '0;
    if (rst_n && load) begin
      in_ready[gnt] = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Output register. A load wins over a drain, so a simultaneous drain and
  // load replaces the word and keeps out_valid high. On a drain without a
  // load only out_valid drops; data and select keep their stale values.
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= chan_data[gnt];
      out_sel   <= gnt;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Round-robin pointer: moves to the slot after the winner, but only when a
  // word is actually loaded, so back-pressure freezes the rotation.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (MODE == 0 && load) begin
      if (gnt == SEL_W'(N - 1)) begin
        ptr <= '0;
      end else begin
        ptr <= gnt + SEL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_arb.sv
// ---------------------------------------------------------------------------
// tb_rr_mux_arb
//
// Directed bench for rr_mux_arb. Three instances share clock and reset:
//   u4  N=4, MODE 0  fairness, mid-stream reset, back-pressure, idle drain
//   u5  N=5, MODE 0  pointer skip and wrap with a non-power-of-2 N
//   up  N=4, MODE 1  fixed priority and starvation
// Inputs change #1 after a rising edge; outputs are sampled at that point
// (registered values) or #1 later (combinational in_ready).
// ---------------------------------------------------------------------------
module tb_rr_mux_arb;

  logic clk;
  logic rst_n;

  // u4
  logic [3:0]  v4;
  logic [31:0] d4;
  logic [3:0]  rdy4;
  logic        ov4;
  logic [7:0]  od4;
  logic [1:0]  os4;
  logic        or4;

  // u5
  logic [4:0]  v5;
  logic [39:0] d5;
  logic [4:0]  rdy5;
  logic        ov5;
  logic [7:0]  od5;
  logic [2:0]  os5;
  logic        or5;

  // up
  logic [3:0]  vp;
  logic [31:0] dp;
  logic [3:0]  rdyp;
  logic        ovp;
  logic [7:0]  odp;
  logic [1:0]  osp;
  logic        orp;

  int checks = 0;
  int errors = 0;

  rr_mux_arb #(.WIDTH(8), .N(4), .MODE(0)) u4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v4), .in_data(d4), .in_ready(rdy4),
    .out_valid(ov4), .out_data(od4), .out_sel(os4), .out_ready(or4)
  );

  rr_mux_arb #(.WIDTH(8), .N(5), .MODE(0)) u5 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v5), .in_data(d5), .in_ready(rdy5),
    .out_valid(ov5), .out_data(od5), .out_sel(os5), .out_ready(or5)
  );

  rr_mux_arb #(.WIDTH(8), .N(4), .MODE(1)) up (
    .clk(clk), .rst_n(rst_n),
    .in_valid(vp), .in_data(dp), .in_ready(rdyp),
    .out_valid(ovp), .out_data(odp), .out_sel(osp), .out_ready(orp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    v4 = '0; d4 = '0; or4 = 1'b0;
    v5 = '0; d5 = '0; or5 = 1'b0;
    vp = '0; dp = '0; orp = 1'b0;

    // ---- reset state ----
    #2;
    check("rst_ov4",  40'(ov4), 40'h0);
    check("rst_od4",  40'(od4), 40'h0);
    check("rst_os4",  40'(os4), 40'h0);
    check("rst_ov5",  40'(ov5), 40'h0);
    check("rst_ovp",  40'(ovp), 40'h0);
    v4 = 4'hF;
    #1;
    check("rst_rdy4_forced", 40'(rdy4), 40'h0);
    v4 = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // ---- round-robin fairness, N=4 ----
    v4  = 4'hF;
    d4  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    or4 = 1'b1;
    #1;
    check("rr_rdy_first", 40'(rdy4), 40'h1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("rr_sel_%0d", i),  40'(os4), 40'(i % 4));
      check($sformatf("rr_data_%0d", i), 40'(od4), 40'(8'hA0 + (i % 4)));
      check($sformatf("rr_ov_%0d", i),   40'(ov4), 40'h1);
      check($sformatf("rr_rdy_%0d", i),  40'(rdy4), 40'(4'b0001 << ((i + 1) % 4)));
    end

    // ---- asynchronous reset mid-stream with out_valid = 1 ----
    rst_n = 1'b0;
    #1;
    check("mid_rst_ov",  40'(ov4),  40'h0);
    check("mid_rst_od",  40'(od4),  40'h0);
    check("mid_rst_os",  40'(os4),  40'h0);
    check("mid_rst_rdy", 40'(rdy4), 40'h0);
    @(negedge clk);
    rst_n = 1'b1;
    v4 = 4'b1100;
    #1;
    check("post_rst_rdy", 40'(rdy4), 40'b0100);
    tick();
    check("post_rst_sel",  40'(os4), 40'h2);
    check("post_rst_data", 40'(od4), 40'hA2);

    // ---- back-pressure: ptr is 3 now ----
    v4 = 4'b0100;
    d4 = {8'h73, 8'h5C, 8'hA1, 8'hA0};
    tick();
    check("bp_load_data", 40'(od4), 40'h5C);
    check("bp_load_sel",  40'(os4), 40'h2);
    or4 = 1'b0;
    #1;
    check("bp_rdy_now", 40'(rdy4), 40'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("bp_hold_data_%0d", i), 40'(od4),  40'h5C);
      check($sformatf("bp_hold_ov_%0d", i),   40'(ov4),  40'h1);
      check($sformatf("bp_hold_sel_%0d", i),  40'(os4),  40'h2);
      check($sformatf("bp_hold_rdy_%0d", i),  40'(rdy4), 40'h0);
    end
    // Frozen ptr = 3 means channel 3 wins with all channels valid.
    v4  = 4'hF;
    or4 = 1'b1;
    #1;
    check("bp_release_rdy", 40'(rdy4), 40'b1000);
    tick();
    check("bp_release_sel",  40'(os4), 40'h3);
    check("bp_release_data", 40'(od4), 40'h73);
    check("bp_release_ov",   40'(ov4), 40'h1);

    // ---- idle drain: one word from channel 1 (ptr is 0 now) ----
    v4 = 4'b0010;
    d4 = {8'h73, 8'h5C, 8'h11, 8'hA0};
    #1;
    check("drain_rdy", 40'(rdy4), 40'b0010);
    tick();
    check("drain_load_ov",   40'(ov4), 40'h1);
    check("drain_load_sel",  40'(os4), 40'h1);
    check("drain_load_data", 40'(od4), 40'h11);
    v4 = '0;
    #1;
    check("drain_idle_rdy", 40'(rdy4), 40'h0);
    tick();
    check("drain_ov0",   40'(ov4), 40'h0);
    check("drain_sel",   40'(os4), 40'h1);
    check("drain_stale", 40'(od4), 40'h11);
    tick();
    check("drain_ov0_b", 40'(ov4), 40'h0);

    // ---- pointer skip and wrap, N=5; invalid channels carry X data ----
    v5  = 5'b10010;
    d5  = {8'hB4, 8'hxx, 8'hxx, 8'hB1, 8'hxx};
    or5 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("wrap_rdy_%0d", i), 40'(rdy5), (i % 2 == 0) ? 40'b00010 : 40'b10000);
      tick();
      check($sformatf("wrap_sel_%0d", i),  40'(os5), (i % 2 == 0) ? 40'h1 : 40'h4);
      check($sformatf("wrap_data_%0d", i), 40'(od5), (i % 2 == 0) ? 40'hB1 : 40'hB4);
    end

    // ---- fixed priority, MODE 1 ----
    vp  = 4'b1001;
    dp  = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
    orp = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("fp_rdy_%0d", i), 40'(rdyp), 40'b0001);
      tick();
      check($sformatf("fp_sel_%0d", i),  40'(osp), 40'h0);
      check($sformatf("fp_data_%0d", i), 40'(odp), 40'hC0);
    end
    vp = 4'b1000;
    #1;
    check("fp_drop_rdy", 40'(rdyp), 40'b1000);
    tick();
    check("fp_drop_sel",  40'(osp), 40'h3);
    check("fp_drop_data", 40'(odp), 40'hC3);
    check("fp_drop_ov",   40'(ovp), 40'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
